// File: rtl/fp_mult_stream.sv
// Streaming floating-point multiplier: operand register, combinational multiply/round,
// then a STAGES-deep result shift register under a single valid/ready advance.
module fp_mult_stream #(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int STAGES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic [2:0]             rnd,
  output logic [EXP_W+MAN_W:0]   z,
  output logic [7:0]             status,
  output logic                   out_valid,
  input  logic                   out_ready
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * (MAN_W + 1);
  localparam int XW = EXP_W + 2;

  localparam logic [XW-1:0]    BIAS     = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic [EXP_W-1:0] EXP_MAX  = '1;
  localparam logic [EXP_W-1:0] EXP_TOP  = EXP_MAX - EXP_W'(1);
  localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
  localparam logic [MAN_W-1:0] QNAN_FR  = MAN_W'(1) << (MAN_W - 1);

  localparam logic [2:0] RND_NEAR = 3'b000;
  localparam logic [2:0] RND_ZERO = 3'b001;
  localparam logic [2:0] RND_PINF = 3'b010;
  localparam logic [2:0] RND_NINF = 3'b011;
  localparam logic [2:0] RND_NUP  = 3'b100;
  localparam logic [2:0] RND_AWAY = 3'b101;

  localparam logic [7:0] ST_ZERO = 8'h01;
  localparam logic [7:0] ST_INF  = 8'h02;
  localparam logic [7:0] ST_NAN  = 8'h04;
  localparam logic [7:0] ST_TINY = 8'h08;
  localparam logic [7:0] ST_HUGE = 8'h10;
  localparam logic [7:0] ST_INEX = 8'h20;

  logic                     advance;
  logic                     op_v;
  logic [W-1:0]             op_a, op_b;
  logic [2:0]               op_rnd;
  logic [STAGES-1:0]        res_v;
  logic [STAGES-1:0][W-1:0] res_z;
  logic [STAGES-1:0][7:0]   res_st;

  logic                sign, a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic [EXP_W-1:0]    ea, eb;
  logic [MAN_W-1:0]    fa, fb, frac_r;
  logic [PW-1:0]       prod, prod_n;
  logic [MAN_W:0]      sig;
  logic [MAN_W+1:0]    sig_r;
  logic                guard, sticky, inexact, inc, away, ovf, unf;
  logic [2:0]          mode;
  logic [XW-1:0]       exp_pre, exp_r;
  logic [W-1:0]        r_z;
  logic [7:0]          r_st;

  always_comb begin
    sign   = op_a[W-1] ^ op_b[W-1];
    ea     = op_a[W-2:MAN_W];
    eb     = op_b[W-2:MAN_W];
    fa     = op_a[MAN_W-1:0];
    fb     = op_b[MAN_W-1:0];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == EXP_MAX) && (fa == '0);
    b_inf  = (eb == EXP_MAX) && (fb == '0);
    a_nan  = (ea == EXP_MAX) && (fa != '0);
    b_nan  = (eb == EXP_MAX) && (fb != '0);
    mode   = (op_rnd > RND_AWAY) ? RND_NEAR : op_rnd;

    // product lies in [1,4); a single left shift normalises the [1,2) case
    prod    = PW'({1'b1, fa}) * PW'({1'b1, fb});
    prod_n  = prod[PW-1] ? prod : (prod << 1);
    sig     = prod_n[PW-1 -: MAN_W+1];
    guard   = prod_n[MAN_W];
    sticky  = |prod_n[MAN_W-1:0];
    inexact = guard | sticky;
    exp_pre = XW'(ea) + XW'(eb) - BIAS + XW'(prod[PW-1]);
    away    = (mode == RND_AWAY) || ((mode == RND_PINF) && !sign) ||
              ((mode == RND_NINF) && sign);

    case (mode)
      RND_NEAR: inc = guard & (sticky | sig[0]);
      RND_ZERO: inc = 1'b0;
      RND_NUP:  inc = guard;
      default:  inc = away & inexact;
    endcase

    sig_r  = {1'b0, sig} + {{(MAN_W+1){1'b0}}, inc};
    exp_r  = exp_pre + XW'(sig_r[MAN_W+1]);
    frac_r = sig_r[MAN_W+1] ? sig_r[MAN_W:1] : sig_r[MAN_W-1:0];
    ovf    = $signed(exp_r) >= $signed({2'b00, EXP_MAX});
    unf    = $signed(exp_r) < $signed(XW'(1));

    r_z  = {sign, exp_r[EXP_W-1:0], frac_r};
    r_st = inexact ? ST_INEX : 8'h00;
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      r_z  = {1'b0, EXP_MAX, QNAN_FR};
      r_st = ST_NAN;
    end else if (a_inf || b_inf) begin
      r_z  = {sign, EXP_MAX, {MAN_W{1'b0}}};
      r_st = ST_INF;
    end else if (a_zero || b_zero) begin
      r_z  = {sign, {(W-1){1'b0}}};
      r_st = ST_ZERO;
    end else if (ovf) begin
      if ((mode == RND_NEAR) || (mode == RND_NUP) || away) begin
        r_z  = {sign, EXP_MAX, {MAN_W{1'b0}}};
        r_st = ST_INF | ST_HUGE | ST_INEX;
      end else begin
        r_z  = {sign, EXP_TOP, {MAN_W{1'b1}}};
        r_st = ST_HUGE | ST_INEX;
      end
    end else if (unf) begin
      if (away) begin
        r_z  = {sign, EXP_ONE, {MAN_W{1'b0}}};
        r_st = ST_TINY | ST_INEX;
      end else begin
        r_z  = {sign, {(W-1){1'b0}}};
        r_st = ST_ZERO | ST_TINY | ST_INEX;
      end
    end
  end

  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance && rst;
  assign out_valid = res_v[STAGES-1];
  assign z         = res_z[STAGES-1];
  assign status    = res_st[STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      op_v   <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      op_rnd <= '0;
      res_v  <= '0;
      res_z  <= '0;
      res_st <= '0;
    end else if (advance) begin
      op_v   <= in_valid;
      op_a   <= a;
      op_b   <= b;
      op_rnd <= rnd;
      res_v  <= {res_v[STAGES-2:0], op_v};
      res_z  <= {res_z[STAGES-2:0], r_z};
      res_st <= {res_st[STAGES-2:0], r_st};
    end
  end
endmodule
